// File: rtl/wash_motor_drv.sv
// ============================================================================
//  Module  : wash_motor_drv
//  Brief   : Drum-motor H-bridge driver with break-before-make dead interval,
//            illegal-command fault trap and optional end-of-cycle buzzer
//            (enabled by defining WASH_DRV_BUZZER_EN).
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_motor_drv #(
  parameter int DEAD_CYC = 2,
  parameter int CNT_W    = 4,
  parameter int BUZZ_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] motor,
  input  logic       compl_n,
  output logic       hb_fwd,
  output logic       hb_rev,
  output logic       busy,
  output logic       fault,
  output logic       buzz
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_REV   = 3'd2,
    S_DEAD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_REV  = 2'b10;
  localparam logic [1:0] CMD_ILL  = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd;
  logic             hb_fwd_q, hb_rev_q, busy_q, fault_q;

  // A completed wash always forces a stop command.
  assign cmd = compl_n ? motor : CMD_STOP;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (cmd)
          CMD_FWD: state_d = S_FWD;
          CMD_REV: state_d = S_REV;
          CMD_ILL: state_d = S_FAULT;
          default: state_d = S_IDLE;
        endcase
      end
      S_FWD: begin
        if (cmd == CMD_ILL) begin
          state_d = S_FAULT;
        end else if (cmd != CMD_FWD) begin
          state_d = S_DEAD;
          cnt_d   = CNT_W'(DEAD_CYC - 1);
        end
      end
      S_REV: begin
        if (cmd == CMD_ILL) begin
          state_d = S_FAULT;
        end else if (cmd != CMD_REV) begin
          state_d = S_DEAD;
          cnt_d   = CNT_W'(DEAD_CYC - 1);
        end
      end
      S_DEAD: begin
        if (cmd == CMD_ILL) begin
          state_d = S_FAULT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          unique case (cmd)
            CMD_FWD: state_d = S_FWD;
            CMD_REV: state_d = S_REV;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_FAULT: begin
        if (cmd == CMD_STOP) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode, so they are a
  // pure function of the state register without any combinational glitching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hb_fwd_q <= 1'b0;
      hb_rev_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hb_fwd_q <= (state_d == S_FWD);
      hb_rev_q <= (state_d == S_REV);
      busy_q   <= (state_d == S_DEAD);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign hb_fwd = hb_fwd_q;
  assign hb_rev = hb_rev_q;
  assign busy   = busy_q;
  assign fault  = fault_q;

`ifdef WASH_DRV_BUZZER_EN
  logic             compl_q;
  logic             buzz_q;
  logic [CNT_W-1:0] bcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compl_q <= 1'b1;
      buzz_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      compl_q <= compl_n;
      if (compl_q && !compl_n) begin
        buzz_q <= 1'b1;
        bcnt_q <= CNT_W'(BUZZ_CYC - 1);
      end else if (buzz_q) begin
        if (bcnt_q == '0) buzz_q <= 1'b0;
        else              bcnt_q <= bcnt_q - CNT_W'(1);
      end
    end
  end

  assign buzz = buzz_q;
`else
  assign buzz = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wash_motor_drv.sv
// ============================================================================
//  Module  : tb_wash_motor_drv
//  Brief   : Directed + randomized bench for wash_motor_drv against a
//            behavioural direction/dead-time model.
//  Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wash_motor_drv;

  localparam int DEAD_CYC = 2;
  localparam int CNT_W    = 4;
  localparam int BUZZ_CYC = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] motor;
  logic       compl_n;
  logic       hb_fwd, hb_rev, busy, fault, buzz;

  int n_tests;
  int n_fail;

  // Model: drum direction (0 off, 1 forward, 2 reverse), cycles of dead time
  // still to serve, latched fault, and buzzer cycles still to sound.
  int m_dir;
  int m_dead;
  bit m_flt;
  int m_buzz;
  bit m_prev_c;

  wash_motor_drv #(
    .DEAD_CYC (DEAD_CYC),
    .CNT_W    (CNT_W),
    .BUZZ_CYC (BUZZ_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .motor   (motor),
    .compl_n (compl_n),
    .hb_fwd  (hb_fwd),
    .hb_rev  (hb_rev),
    .busy    (busy),
    .fault   (fault),
    .buzz    (buzz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int cmd;
    if (!rst_n) begin
      m_dir    = 0;
      m_dead   = 0;
      m_flt    = 1'b0;
      m_buzz   = 0;
      m_prev_c = 1'b1;
      return;
    end
    cmd = compl_n ? int'(motor) : 0;
    if (cmd == 3) begin
      m_flt  = 1'b1;
      m_dir  = 0;
      m_dead = 0;
    end else if (m_flt) begin
      if (cmd == 0) m_flt = 1'b0;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_dir = cmd;
    end else if (m_dir == 0) begin
      m_dir = cmd;
    end else if (cmd != m_dir) begin
      m_dir  = 0;
      m_dead = DEAD_CYC;
    end
`ifdef WASH_DRV_BUZZER_EN
    if (m_prev_c && !compl_n) m_buzz = BUZZ_CYC;
    else if (m_buzz > 0)      m_buzz--;
`endif
    m_prev_c = compl_n;
  endtask

  task automatic cyc(input logic r, input logic [1:0] m, input logic c);
    logic [7:0] exp_v, obs_v;
    rst_n   = r;
    motor   = m;
    compl_n = c;
    @(posedge clk);
    model_step();
    #1;
    exp_v = {3'b000,
             (m_dir == 1 && m_dead == 0 && !m_flt),
             (m_dir == 2 && m_dead == 0 && !m_flt),
             (m_dead > 0),
             m_flt,
             (m_buzz > 0)};
    obs_v = {3'b000, hb_fwd, hb_rev, busy, fault, buzz};
    check("outs{fwd,rev,busy,fault,buzz}", obs_v, exp_v);
    check("legs_exclusive", {7'd0, hb_fwd & hb_rev}, 8'd0);
  endtask

  initial begin
    logic [1:0] rm;
    logic       rc;
    logic       rr;
    n_tests  = 0;
    n_fail   = 0;
    m_dir    = 0;
    m_dead   = 0;
    m_flt    = 1'b0;
    m_buzz   = 0;
    m_prev_c = 1'b1;
    rst_n    = 1'b0;
    motor    = 2'b00;
    compl_n  = 1'b1;
    #2;

    // Reset then forward start
    cyc(1'b0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 1'b1);
    check("reset_state", {3'b000, hb_fwd, hb_rev, busy, fault, buzz}, 8'd0);
    repeat (3) cyc(1'b1, 2'b01, 1'b1);
    check("fwd_after_start", {6'd0, hb_fwd, hb_rev}, 8'b10);
    // Direction change forward -> reverse
    repeat (4) cyc(1'b1, 2'b10, 1'b1);
    // Reverse -> forward -> reverse -> stop inside dead interval
    cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b1, 2'b10, 1'b1);
    repeat (4) cyc(1'b1, 2'b00, 1'b1);
    // Fault trap and recovery
    repeat (2) cyc(1'b1, 2'b01, 1'b1);
    repeat (2) cyc(1'b1, 2'b11, 1'b1);
    check("fault_set", {7'd0, fault}, 8'd1);
    repeat (2) cyc(1'b1, 2'b01, 1'b1);
    repeat (2) cyc(1'b1, 2'b00, 1'b1);
    check("fault_clear", {7'd0, fault}, 8'd0);
    // Wash complete while reversing
    repeat (3) cyc(1'b1, 2'b10, 1'b1);
    repeat (5) cyc(1'b1, 2'b10, 1'b0);
    repeat (2) cyc(1'b1, 2'b00, 1'b1);
    // Reset asserted in the first dead cycle
    repeat (2) cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b1, 2'b10, 1'b1);
    cyc(1'b0, 2'b10, 1'b1);
    check("reset_in_dead", {3'b000, hb_fwd, hb_rev, busy, fault, buzz}, 8'd0);
    repeat (2) cyc(1'b1, 2'b01, 1'b1);

    // Randomized traffic with sticky commands so states get to settle
    rm = 2'b00;
    rc = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rc = ~rc;
      rr = ($urandom_range(0, 99) != 0);
      cyc(rr, rm, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wash_motor_drv.md
Name: wash_motor_drv

Overview:
- Downstream stage of the washer control FSM.
- Consumes its 2-bit motor command and active-low completion flag, and drives the two legs of the drum-motor H-bridge.
- Guarantees a break-before-make dead interval on every direction change or stop, so both legs are never on together.
- Traps illegal commands as a fault, and can optionally sound an end-of-cycle buzzer.

Parameters:
- DEAD_CYC, 2: dead interval in clk cycles; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the dead/buzz down-counter.
- BUZZ_CYC, 3: buzzer pulse length in clk cycles; used only with the optional feature; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock; rising edge; 1 Hz in the washer build.
- rst_n  input  1  synchronous, active-low reset.
- motor  input  2  command from the wash FSM: 00 stop, 01 forward, 10 reverse, 11 illegal.
- compl_n  input  1  active-low wash-complete flag from the wash FSM.
- hb_fwd  output  1  forward H-bridge leg enable, active high.
- hb_rev  output  1  reverse H-bridge leg enable, active high.
- busy  output  1  high while in the dead interval.
- fault  output  1  high while an illegal command is trapped.
- buzz  output  1  end-of-cycle buzzer drive, active high.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge. rst_n low has priority over everything else.
- Reset state: IDLE, counter 0. hb_fwd=0, hb_rev=0, busy=0, fault=0, buzz=0.
- Effective command: cmd = 00 whenever compl_n=0, otherwise cmd = motor. A completed wash always stops the drum.
- Outputs are registered. Each is decoded from the state register only (Moore), so the response appears 1 cycle after the input changes.
- State outputs:
  - IDLE: both legs off.
  - FWD: hb_fwd=1.
  - REV: hb_rev=1.
  - DEAD: both legs off, busy=1.
  - FAULT: both legs off, fault=1.
- IDLE transitions: cmd 01 -> FWD; cmd 10 -> REV; cmd 11 -> FAULT; cmd 00 -> stay. No dead time is needed because the legs are already off.
- FWD transitions: cmd 01 -> stay; cmd 00 or 10 -> DEAD, loading counter with DEAD_CYC-1; cmd 11 -> FAULT.
- REV transitions: mirror of FWD (cmd 10 stays; cmd 00 or 01 -> DEAD; cmd 11 -> FAULT).
- DEAD transitions:
  - Counter != 0: decrement and stay.
  - Counter == 0: act on the current cmd. 00 -> IDLE, 01 -> FWD, 10 -> REV.
  - cmd 11 at any time in DEAD -> FAULT immediately.
  - Net effect: DEAD lasts exactly DEAD_CYC cycles, and the command is re-sampled only on its last cycle. Commands that change during DEAD are absorbed.
- FAULT transitions: stay until cmd == 00, then -> IDLE. fault deasserts on the cycle after 00 is seen.
- Invariant: hb_fwd & hb_rev is never 1, including across reset.
- Reset mid-operation: with rst_n low in FWD, REV or DEAD, the legs are off on the next edge. The dead interval is not honoured on reset, because off is always safe.
- Simultaneous events: compl_n falling while in FWD behaves exactly like cmd 00, i.e. the block enters DEAD.

Optional Feature:
- Macro: WASH_DRV_BUZZER_EN.
- Defined:
  - On a compl_n falling edge (registered compl_n was 1, current is 0, out of reset), buzz goes high for exactly BUZZ_CYC cycles, starting the cycle after the edge.
  - A second falling edge during a pulse restarts the count.
  - Reset clears buzz and the pulse counter.
  - The buzzer logic is independent of the motor state machine.
- Undefined: the buzz port remains present and is tied to 0. No buzzer registers are generated.

Test Plan (DEAD_CYC=2, BUZZ_CYC=3):
- Reset then motor=01: hb_fwd=1 one cycle after; hb_rev=0, busy=0.
- FWD, motor 01->10: next 2 cycles both legs 0 with busy=1; hb_rev=1 on the 3rd cycle; hb_fwd&hb_rev never 1.
- FWD, motor 01->10->00 within the dead interval: DEAD lasts 2 cycles, then IDLE with both legs 0; REV is never entered.
- motor=11 from FWD: next cycle both legs 0 and fault=1; fault holds while motor stays 11 or goes to 01; after motor=00, fault=0 and IDLE follow the next cycle.
- REV, compl_n 1->0 with motor=10: DEAD for 2 cycles, then IDLE. With WASH_DRV_BUZZER_EN, buzz=1 for exactly 3 cycles starting 1 cycle after the edge. Without it, buzz=0 throughout.
- rst_n=0 asserted for 1 cycle while in DEAD with counter=1: next edge gives all outputs 0 in IDLE, and motor=01 afterwards gives hb_fwd=1 one cycle later.
